// File: rtl/sub_result_if.sv
// Valid/ready bus between the subtractor front end, the result FIFO and its consumer.
// slave  : seen by the result FIFO (accepts upstream entries, drives the head entry and status).
// master : seen by the agent that drives upstream entries and consumes results.
interface sub_result_if #(
   parameter int unsigned WIDTH = 6,
   parameter int unsigned AW    = 2
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic [WIDTH-1:0] in_diff;
   logic             in_bout;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_diff;
   logic             out_borrow;
   logic             out_zero;
   logic             out_neg;
   logic             out_ovf;
   logic             out_mismatch;
   logic [AW:0]      count;
   logic             full;
   logic             empty;
   logic             err_sticky;

   modport slave (
      input  in_valid, in_a, in_b, in_diff, in_bout, out_ready,
      output in_ready, out_valid, out_diff, out_borrow, out_zero, out_neg,
             out_ovf, out_mismatch, count, full, empty, err_sticky
   );

   modport master (
      output in_valid, in_a, in_b, in_diff, in_bout, out_ready,
      input  in_ready, out_valid, out_diff, out_borrow, out_zero, out_neg,
             out_ovf, out_mismatch, count, full, empty, err_sticky
   );
endinterface

// File: rtl/sub_result_fifo.sv
// Registered result stage behind the ripple-borrow subtractor: a small
// first-word-fall-through FIFO that stores diff/borrow with status flags
// (zero, neg, signed overflow, self-check mismatch) computed at push time.
// Optional feature macro: SUB_SAT_EN -- entries pushed with borrow-out set
// store diff = 0 (unsigned saturation); zero/neg follow the stored value.
module sub_result_fifo #(
   parameter int unsigned WIDTH = 6,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = 2
) (
   input logic         clk,
   input logic         rst,
   sub_result_if.slave bus
);
   localparam int unsigned CW = AW + 1;

   typedef struct packed {
      logic [WIDTH-1:0] diff;
      logic             borrow;
      logic             zero;
      logic             neg;
      logic             ovf;
      logic             mismatch;
   } entry_t;

   entry_t           mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             err_q, err_d;

   logic             full_c, empty_c, push_c, pop_c;
   logic [WIDTH:0]   ref_c;
   logic [WIDTH-1:0] diff_st_c;
   entry_t           new_c, head_c;

   assign full_c  = (count_q == CW'(DEPTH));
   assign empty_c = (count_q == '0);
   assign push_c  = bus.in_valid & ~full_c;
   assign pop_c   = ~empty_c & bus.out_ready;

   // Build the entry to store: reference a-b with borrow in the extra MSB, flags from it.
   always_comb begin
      ref_c = {1'b0, bus.in_a} - {1'b0, bus.in_b};
`ifdef SUB_SAT_EN
      diff_st_c = bus.in_bout ? '0 : bus.in_diff;
`else
      diff_st_c = bus.in_diff;
`endif
      new_c          = '0;
      new_c.diff     = diff_st_c;
      new_c.borrow   = bus.in_bout;
      new_c.zero     = (diff_st_c == '0);
      new_c.neg      = diff_st_c[WIDTH-1];
      new_c.ovf      = (bus.in_a[WIDTH-1] != bus.in_b[WIDTH-1]) &
                       (bus.in_diff[WIDTH-1] != bus.in_a[WIDTH-1]);
      new_c.mismatch = (bus.in_diff != ref_c[WIDTH-1:0]) | (bus.in_bout != ref_c[WIDTH]);
   end

   // Next-state for pointers, occupancy and the sticky error flag.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      err_d    = err_q;
      if (push_c) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
         err_d    = err_q | new_c.mismatch;
      end
      if (pop_c) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(push_c) - CW'(pop_c);
   end

   // Control state registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         err_q    <= err_d;
      end
   end

   // Entry storage; stale contents are unreachable once count is cleared.
   always_ff @(posedge clk) begin
      if (push_c) begin
         mem_q[wr_ptr_q] <= new_c;
      end
   end

   // Head entry falls through to the outputs, forced to zero while empty.
   always_comb begin
      head_c = '0;
      if (!empty_c) begin
         head_c = mem_q[rd_ptr_q];
      end
   end

   assign bus.in_ready     = ~full_c;
   assign bus.out_valid    = ~empty_c;
   assign bus.out_diff     = head_c.diff;
   assign bus.out_borrow   = head_c.borrow;
   assign bus.out_zero     = head_c.zero;
   assign bus.out_neg      = head_c.neg;
   assign bus.out_ovf      = head_c.ovf;
   assign bus.out_mismatch = head_c.mismatch;
   assign bus.count        = count_q;
   assign bus.full         = full_c;
   assign bus.empty        = empty_c;
   assign bus.err_sticky   = err_q;
endmodule

// File: tb/tb_sub_result_fifo.sv
// Directed + short random bench for sub_result_fifo with a queue scoreboard.
module tb_sub_result_fifo;
   localparam int unsigned WIDTH = 6;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned AW    = 2;

   typedef struct packed {
      logic [5:0] diff;
      logic       borrow;
      logic       zero;
      logic       neg;
      logic       ovf;
      logic       mis;
   } exp_t;

   logic clk;
   logic rst;
   sub_result_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

   sub_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   n_checks = 0;
   int   n_errors = 0;
   exp_t sb[$];
   logic m_err;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [5:0] a, input logic [5:0] b,
                                  input logic [5:0] d, input logic bo);
      exp_t       e;
      logic [5:0] wrap;
      logic       brw;
      wrap     = a - b;
      brw      = (a < b);
      e.mis    = (d != wrap) || (bo != brw);
      e.ovf    = (a[5] != b[5]) && (d[5] != a[5]);
      e.borrow = bo;
`ifdef SUB_SAT_EN
      e.diff   = bo ? 6'd0 : d;
`else
      e.diff   = d;
`endif
      e.zero   = (e.diff == 6'd0);
      e.neg    = e.diff[5];
      return e;
   endfunction

   task automatic check_all();
      exp_t h;
      int   n;
      n = sb.size();
      h = (n > 0) ? sb[0] : exp_t'(0);
      chk("out_valid",    32'(bus.out_valid),    32'(n != 0));
      chk("out_diff",     32'(bus.out_diff),     32'(h.diff));
      chk("out_borrow",   32'(bus.out_borrow),   32'(h.borrow));
      chk("out_zero",     32'(bus.out_zero),     32'(h.zero));
      chk("out_neg",      32'(bus.out_neg),      32'(h.neg));
      chk("out_ovf",      32'(bus.out_ovf),      32'(h.ovf));
      chk("out_mismatch", 32'(bus.out_mismatch), 32'(h.mis));
      chk("count",        32'(bus.count),        32'(n));
      chk("full",         32'(bus.full),         32'(n == DEPTH));
      chk("empty",        32'(bus.empty),        32'(n == 0));
      chk("in_ready",     32'(bus.in_ready),     32'(n != DEPTH));
      chk("err_sticky",   32'(bus.err_sticky),   32'(m_err));
   endtask

   // One clock: drive inputs, check outputs, advance DUT and model together.
   task automatic cycle(input bit v, input logic [5:0] a, input logic [5:0] b,
                        input logic [5:0] d, input logic bo, input bit rdy);
      bit   push, pop;
      exp_t e;
      bus.in_valid  = v;
      bus.in_a      = a;
      bus.in_b      = b;
      bus.in_diff   = d;
      bus.in_bout   = bo;
      bus.out_ready = rdy;
      #1;
      check_all();
      e    = model(a, b, d, bo);
      push = v && (sb.size() < DEPTH);
      pop  = rdy && (sb.size() > 0);
      @(posedge clk);
      if (pop) void'(sb.pop_front());
      if (push) begin
         sb.push_back(e);
         if (e.mis) m_err = 1'b1;
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      @(posedge clk);
      sb.delete();
      m_err = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic [5:0] ea[6];
      logic [5:0] eb[6];
      logic [5:0] ra, rb, rd;
      logic       rbo;
      rst = 1'b1;
      m_err = 1'b0;
      bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0;
      bus.in_diff = '0; bus.in_bout = 1'b0; bus.out_ready = 1'b0;
      @(negedge clk);
      do_reset();
      #1;
      check_all();
      chk("rst_empty", 32'(bus.empty), 32'd1);

      // Basic positive result.
      cycle(1, 6'b001010, 6'b000100, 6'b000110, 1'b0, 0);
      chk("t1_valid", 32'(bus.out_valid), 32'd1);
      chk("t1_diff",  32'(bus.out_diff),  32'b000110);
      chk("t1_count", 32'(bus.count),     32'd1);
      cycle(0, 0, 0, 0, 0, 1);

      // Zero result.
      cycle(1, 6'b000001, 6'b000001, 6'b000000, 1'b0, 0);
      chk("t2_zero", 32'(bus.out_zero), 32'd1);
      cycle(0, 0, 0, 0, 0, 1);

      // Borrow with signed overflow (saturates when SUB_SAT_EN).
      cycle(1, 6'b000001, 6'b100000, 6'b100001, 1'b1, 0);
`ifdef SUB_SAT_EN
      chk("t3_diff", 32'(bus.out_diff), 32'd0);
      chk("t3_zero", 32'(bus.out_zero), 32'd1);
      chk("t3_neg",  32'(bus.out_neg),  32'd0);
`else
      chk("t3_diff", 32'(bus.out_diff), 32'b100001);
      chk("t3_neg",  32'(bus.out_neg),  32'd1);
`endif
      chk("t3_borrow", 32'(bus.out_borrow),   32'd1);
      chk("t3_ovf",    32'(bus.out_ovf),      32'd1);
      chk("t3_mis",    32'(bus.out_mismatch), 32'd0);
      cycle(0, 0, 0, 0, 0, 1);

      // Fill to full, hold the 5th, then pop-only and push+pop cycles.
      for (int i = 0; i < 6; i++) begin
         ea[i] = 6'(i * 7 + 3);
         eb[i] = 6'(i * 5);
      end
      for (int i = 0; i < 4; i++) cycle(1, ea[i], eb[i], ea[i] - eb[i], ea[i] < eb[i], 0);
      chk("fill_full",  32'(bus.full),     32'd1);
      chk("fill_rdy",   32'(bus.in_ready), 32'd0);
      chk("fill_count", 32'(bus.count),    32'd4);
      cycle(1, ea[4], eb[4], ea[4] - eb[4], ea[4] < eb[4], 0);
      chk("hold_count", 32'(bus.count), 32'd4);
      cycle(1, ea[4], eb[4], ea[4] - eb[4], ea[4] < eb[4], 1);
      chk("pop_only_count", 32'(bus.count), 32'd3);
      cycle(1, ea[4], eb[4], ea[4] - eb[4], ea[4] < eb[4], 1);
      chk("push_pop_count", 32'(bus.count), 32'd3);
      chk("order_head", 32'(bus.out_diff), 32'(ea[2] - eb[2]));
      for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 1);
      chk("drained", 32'(bus.empty), 32'd1);

      // Mismatching entry sets the sticky error.
      cycle(1, 6'b001010, 6'b000100, 6'b000111, 1'b0, 0);
      chk("t5_mis", 32'(bus.out_mismatch), 32'd1);
      chk("t5_err", 32'(bus.err_sticky),   32'd1);
      cycle(0, 0, 0, 0, 0, 1);
      chk("t5_err_after_pop", 32'(bus.err_sticky), 32'd1);

      // Reset in the middle of traffic.
      cycle(1, 6'd20, 6'd3, 6'd17, 1'b0, 0);
      cycle(1, 6'd3, 6'd20, 6'(3 - 20), 1'b1, 0);
      do_reset();
      #1;
      chk("mrst_count", 32'(bus.count),      32'd0);
      chk("mrst_empty", 32'(bus.empty),      32'd1);
      chk("mrst_err",   32'(bus.err_sticky), 32'd0);
      chk("mrst_valid", 32'(bus.out_valid),  32'd0);
      check_all();

      // Random traffic with occasional corrupted results.
      for (int i = 0; i < 60; i++) begin
         ra  = 6'($urandom_range(0, 63));
         rb  = 6'($urandom_range(0, 63));
         rd  = ra - rb;
         rbo = (ra < rb);
         if ($urandom_range(0, 9) == 0) rd = rd ^ 6'b000100;
         if ($urandom_range(0, 14) == 0) rbo = ~rbo;
         cycle(1'($urandom_range(0, 1)), ra, rb, rd, rbo, 1'($urandom_range(0, 1)));
      end
      for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 0, 1);
      #1;
      check_all();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
